startup_usr_ctrl: RTL and testbench
===================================

Name: startup_usr_ctrl

Overview:
User-side controller for the device STARTUP primitive. It consumes the primitive's outputs (EOS, PREQ) and produces the primitive's user-facing inputs (USRCCLKO/USRCCLKTS, USRDONEO/USRDONETS, PACK). It sequences the post-configuration dummy CCLK edges, generates a divided user CCLK on request for SPI flash access, and runs the PREQ/PACK reprogram handshake. It sits between fabric SPI/boot logic and the STARTUP instance.

Parameters:
CCLK_DIV, 4, CLK cycles per USRCCLKO half-period (legal >= 1)
DUMMY_CCLKS, 3, USRCCLKO rising edges issued after EOS before READY (legal >= 1)

Ports:
CLK  input  1  system clock
RST  input  1  reset; asynchronous, active-high
EOS  input  1  end-of-startup from primitive; asynchronous, 2-flop synchronized
PREQ  input  1  reprogram request from primitive; asynchronous, 2-flop synchronized
USR_PROG_ACK  input  1  user grants reprogram (level)
CCLK_REQ  input  1  user requests CCLK toggling (level)
USR_DONE  input  1  user request to drive DONE high (level)
USRCCLKO  output  1  user CCLK to primitive
USRCCLKTS  output  1  CCLK tristate (1 = released)
USRDONEO  output  1  DONE value to primitive
USRDONETS  output  1  DONE tristate (1 = released)
PACK  output  1  reprogram acknowledge to primitive
READY  output  1  dummy CCLKs complete, user CCLK available
CCLK_RISE  output  1  one-cycle strobe on each USRCCLKO 0->1 update
PROG_PENDING  output  1  synchronized PREQ seen, not yet acknowledged

Behaviour:
- Reset (async, any time, including mid-operation): USRCCLKO=0, USRCCLKTS=1, USRDONEO=0, USRDONETS=1, PACK=0, READY=0, CCLK_RISE=0, PROG_PENDING=0. Synchronizers, divider and FSM cleared; FSM enters WAIT_EOS.
- All outputs are registered.
- Divider: counter runs 0..CCLK_DIV-1 while the FSM is in DUMMY or RUN. At terminal count, USRCCLKO toggles and the counter returns to 0. The counter is held at 0 in every other state.
- FSM states: WAIT_EOS, DUMMY, IDLE, RUN.
  - WAIT_EOS: when synchronized EOS=1 (2 cycles after EOS rises), enter DUMMY on the next cycle. USRCCLKTS=0 from DUMMY entry onward until reset.
  - DUMMY: count rising edges of USRCCLKO. After the DUMMY_CCLKS-th rising edge is followed by its falling edge, enter IDLE. READY=1 from that cycle onward; READY is sticky until reset.
  - IDLE: if CCLK_REQ=1 and PACK=0, enter RUN.
  - RUN: toggle USRCCLKO. If CCLK_REQ=0 or PACK=1, stay in RUN until the next falling toggle, then enter IDLE. USRCCLKO always parks at 0 and no partial high phase occurs.
- CCLK_RISE: high exactly in the cycle USRCCLKO registers 1, in both DUMMY and RUN.
- EOS deassertion after WAIT_EOS exits is ignored.
- DONE: USRDONETS=~(READY & USR_DONE) and USRDONEO=READY & USR_DONE, both registered (1-cycle latency). USR_DONE before READY has no effect.
- Reprogram handshake:
  - A synchronized PREQ rising edge sets PROG_PENDING.
  - USR_PROG_ACK=1 while PROG_PENDING=1: PACK=1 next cycle and PROG_PENDING clears in the same cycle.
  - PACK holds until synchronized PREQ=0, then clears the next cycle.
  - USR_PROG_ACK without a pending request is ignored.
  - A new PREQ rising edge while PACK=1 is not possible, because PACK clears only after PREQ falls.
- Simultaneous events:
  - PACK rising while in RUN: RUN finishes the current period, then goes to IDLE. CCLK_REQ is ignored while PACK=1.
  - PREQ is handled in every FSM state, including WAIT_EOS.

Test Plan:
- Reset: with CCLK_DIV=2 and DUMMY_CCLKS=3, assert RST mid-cycle -> all outputs at reset values immediately, without waiting for a CLK edge.
- Startup: EOS rises at cycle 0 -> DUMMY entered at cycle 3 with USRCCLKTS=0. USRCCLKO toggles every 2 cycles for 3 rising edges, with 3 CCLK_RISE pulses. READY=1 in the cycle of the 3rd falling edge; USRCCLKO=0 thereafter.
- Run stop: READY=1, CCLK_REQ high 7 cycles then low while USRCCLKO=1 -> USRCCLKO completes its high phase, falls, FSM returns to IDLE. Count of CCLK_RISE pulses equals count of falling edges.
- Handshake: PREQ high -> PROG_PENDING=1 after 2-3 cycles. USR_PROG_ACK pulse -> PACK=1 next cycle, PROG_PENDING=0. PREQ low -> PACK=0 within 3 cycles.
- DONE gating: USR_DONE=1 before READY -> USRDONETS stays 1. After READY -> USRDONETS=0 and USRDONEO=1 one cycle later; USR_DONE low -> both revert the next cycle.
- Conflict: CCLK_REQ=1 in RUN, then PACK asserts -> USRCCLKO stops after the next falling edge. No RUN re-entry while PACK=1, even with CCLK_REQ=1.

Source files
------------

// File: rtl/startup_usr_ctrl.sv
// User-side controller for the STARTUP primitive: post-EOS dummy CCLK edges,
// divided user CCLK on request, and the PREQ/PACK reprogram handshake.
module startup_usr_ctrl #(
  parameter int CCLK_DIV    = 4,
  parameter int DUMMY_CCLKS = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_eos,
  input  logic i_preq,
  input  logic i_usr_prog_ack,
  input  logic i_cclk_req,
  input  logic i_usr_done,
  output logic o_usrcclko,
  output logic o_usrcclkts,
  output logic o_usrdoneo,
  output logic o_usrdonets,
  output logic o_pack,
  output logic o_ready,
  output logic o_cclk_rise,
  output logic o_prog_pending
);

  localparam int DW = (CCLK_DIV > 1) ? $clog2(CCLK_DIV) : 1;
  localparam int RW = $clog2(DUMMY_CCLKS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CCLK_DIV - 1);
  localparam logic [RW-1:0] RISE_LAST = RW'(DUMMY_CCLKS);

  typedef enum logic [1:0] {
    S_WAIT_EOS,
    S_DUMMY,
    S_IDLE,
    S_RUN
  } state_t;

  state_t        r_state;
  logic          r_eos_s1, r_eos_s2;
  logic          r_preq_s1, r_preq_s2, r_preq_d;
  logic [DW-1:0] r_div_cnt;
  logic [RW-1:0] r_rise_cnt;
  logic          r_cclko, r_cclkts, r_ready, r_cclk_rise;
  logic          r_doneo, r_donets;
  logic          r_pack, r_prog_pending;

  logic w_counting, w_toggle, w_fall, w_preq_rise;

  assign w_counting  = (r_state == S_DUMMY) || (r_state == S_RUN);
  assign w_toggle    = w_counting && (r_div_cnt == DIV_LAST);
  assign w_fall      = w_toggle && r_cclko;
  assign w_preq_rise = r_preq_s2 && !r_preq_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_eos_s1  <= 1'b0;
      r_eos_s2  <= 1'b0;
      r_preq_s1 <= 1'b0;
      r_preq_s2 <= 1'b0;
      r_preq_d  <= 1'b0;
    end else begin
      r_eos_s1  <= i_eos;
      r_eos_s2  <= r_eos_s1;
      r_preq_s1 <= i_preq;
      r_preq_s2 <= r_preq_s1;
      r_preq_d  <= r_preq_s2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (!w_counting || w_toggle) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // RUN only leaves on a falling toggle, so USRCCLKO always parks low with full high phases.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_WAIT_EOS;
      r_rise_cnt  <= '0;
      r_cclko     <= 1'b0;
      r_cclkts    <= 1'b1;
      r_ready     <= 1'b0;
      r_cclk_rise <= 1'b0;
    end else begin
      r_cclk_rise <= 1'b0;
      if (w_toggle) begin
        r_cclko     <= ~r_cclko;
        r_cclk_rise <= ~r_cclko;
      end
      case (r_state)
        S_WAIT_EOS: begin
          if (r_eos_s2) begin
            r_state  <= S_DUMMY;
            r_cclkts <= 1'b0;
          end
        end
        S_DUMMY: begin
          if (w_toggle && !r_cclko) begin
            r_rise_cnt <= r_rise_cnt + 1'b1;
          end else if (w_fall && (r_rise_cnt == RISE_LAST)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (i_cclk_req && !r_pack) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_fall && (!i_cclk_req || r_pack)) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_WAIT_EOS;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_doneo  <= 1'b0;
      r_donets <= 1'b1;
    end else begin
      r_doneo  <= r_ready & i_usr_done;
      r_donets <= ~(r_ready & i_usr_done);
    end
  end

  // PACK is held until the synchronized request drops, so no new PREQ edge can overlap it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prog_pending <= 1'b0;
      r_pack         <= 1'b0;
    end else begin
      if (w_preq_rise) begin
        r_prog_pending <= 1'b1;
      end else if (r_prog_pending && i_usr_prog_ack) begin
        r_prog_pending <= 1'b0;
        r_pack         <= 1'b1;
      end
      if (r_pack && !r_preq_s2) begin
        r_pack <= 1'b0;
      end
    end
  end

  assign o_usrcclko     = r_cclko;
  assign o_usrcclkts    = r_cclkts;
  assign o_usrdoneo     = r_doneo;
  assign o_usrdonets    = r_donets;
  assign o_pack         = r_pack;
  assign o_ready        = r_ready;
  assign o_cclk_rise    = r_cclk_rise;
  assign o_prog_pending = r_prog_pending;

endmodule

// File: tb/tb_startup_usr_ctrl.sv
// Self-checking bench for startup_usr_ctrl: directed scenarios plus a
// randomized CCLK request run checked against a period-level model.
module tb_startup_usr_ctrl;

  localparam int DIV    = 2;
  localparam int NDUM   = 3;
  localparam int NRAND  = 240;

  logic clk = 1'b0;
  logic rst, eos, preq, ack, req, usrDone;
  logic usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending;

  int testsRun    = 0;
  int testsFailed = 0;

  logic histReq [NRAND];
  logic obsHi   [NRAND];
  logic obsRise [NRAND];
  logic expHi   [NRAND];
  logic expRise [NRAND];

  startup_usr_ctrl #(.CCLK_DIV(DIV), .DUMMY_CCLKS(NDUM)) dut (
    .i_clk(clk), .i_rst(rst), .i_eos(eos), .i_preq(preq),
    .i_usr_prog_ack(ack), .i_cclk_req(req), .i_usr_done(usrDone),
    .o_usrcclko(usrcclko), .o_usrcclkts(usrcclkts), .o_usrdoneo(usrdoneo),
    .o_usrdonets(usrdonets), .o_pack(pack), .o_ready(ready),
    .o_cclk_rise(cclkRise), .o_prog_pending(progPending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // A run starting at edge k rises at k+DIV and falls at k+2*DIV; it ends at a fall seeing req low.
  task automatic buildRunModel(input int n);
    int k, p, f;
    bit running;
    for (int i = 0; i < n; i++) begin
      expHi[i] = 1'b0;
      expRise[i] = 1'b0;
    end
    k = 0;
    while (k < n) begin
      if (histReq[k]) begin
        p = k;
        running = 1'b1;
        while (running) begin
          for (int j = p + DIV; j < p + 2 * DIV && j < n; j++) expHi[j] = 1'b1;
          if (p + DIV < n) expRise[p + DIV] = 1'b1;
          f = p + 2 * DIV;
          if (f >= n) begin
            running = 1'b0;
            k = n;
          end else if (!histReq[f]) begin
            running = 1'b0;
            k = f + 1;
          end else begin
            p = f;
          end
        end
      end else begin
        k++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; eos = 1'b0; preq = 1'b0; ack = 1'b0; req = 1'b0; usrDone = 1'b0;
    repeat (2) tick();
    testsRun++;
    if ({usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending} !== 8'b01010000) begin
      testsFailed++;
      $display("[TB] FAIL reset_values got %b expected %b",
               {usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending}, 8'b01010000);
    end
    rst = 1'b0;
    repeat (3) tick();
    testsRun++;
    if ({usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending} !== 8'b01010000) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_idle got %b expected %b",
               {usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending}, 8'b01010000);
    end
  endtask

  task automatic test_handshake();
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    testsRun++;
    if ({pack, progPending} !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL ack_without_request got %b expected 00", {pack, progPending});
    end
    preq = 1'b1;
    tick();
    testsRun++;
    if (progPending !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pending_too_early got %b expected 0", progPending);
    end
    repeat (2) tick();
    testsRun++;
    if (progPending !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pending_set got %b expected 1", progPending);
    end
    repeat ($urandom_range(0, 4)) tick();
    testsRun++;
    if ({pack, progPending} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL pending_hold got %b expected 01", {pack, progPending});
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    testsRun++;
    if ({pack, progPending} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL ack_grant got %b expected 10", {pack, progPending});
    end
    repeat ($urandom_range(1, 5)) tick();
    testsRun++;
    if (pack !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pack_hold got %b expected 1", pack);
    end
    preq = 1'b0;
    repeat (2) tick();
    testsRun++;
    if (pack !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pack_early_clear got %b expected 1", pack);
    end
    tick();
    testsRun++;
    if (pack !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pack_clear got %b expected 0", pack);
    end
  endtask

  task automatic test_startup();
    int   readyEdge, rel, rises;
    logic eHi, eRise, eTs, eReady, eDone;
    readyEdge = 3 + 2 * DIV * NDUM;
    rises = 0;
    usrDone = 1'b1;
    eos = 1'b1;
    for (int j = 1; j <= readyEdge + 4; j++) begin
      tick();
      rel    = j - 3;
      eTs    = (j >= 3) ? 1'b0 : 1'b1;
      eHi    = (rel > 0) && ((rel / DIV) % 2 == 1) && (rel < 2 * DIV * NDUM);
      eRise  = (rel > 0) && (rel % (2 * DIV) == DIV) && (rel < 2 * DIV * NDUM);
      eReady = (j >= readyEdge);
      eDone  = (j >= readyEdge + 1);
      if (cclkRise === 1'b1) rises++;
      testsRun++;
      if ({usrcclko, usrcclkts, ready, cclkRise, usrdoneo, usrdonets} !== {eHi, eTs, eReady, eRise, eDone, ~eDone}) begin
        testsFailed++;
        $display("[TB] FAIL startup_cycle_%0d got %b expected %b", j,
                 {usrcclko, usrcclkts, ready, cclkRise, usrdoneo, usrdonets},
                 {eHi, eTs, eReady, eRise, eDone, ~eDone});
      end
    end
    testsRun++;
    if (rises != NDUM) begin
      testsFailed++;
      $display("[TB] FAIL dummy_rise_count got %0d expected %0d", rises, NDUM);
    end
    usrDone = 1'b0;
    eos = 1'b0;
    repeat (6) tick();
    testsRun++;
    if ({ready, usrcclkts, usrcclko, usrdonets} !== 4'b1001) begin
      testsFailed++;
      $display("[TB] FAIL eos_drop_ignored got %b expected 1001", {ready, usrcclkts, usrcclko, usrdonets});
    end
  endtask

  task automatic test_done();
    for (int i = 0; i < 4; i++) begin
      usrDone = 1'b1;
      tick();
      testsRun++;
      if ({usrdoneo, usrdonets} !== 2'b10) begin
        testsFailed++;
        $display("[TB] FAIL done_drive_%0d got %b expected 10", i, {usrdoneo, usrdonets});
      end
      repeat ($urandom_range(0, 3)) tick();
      usrDone = 1'b0;
      tick();
      testsRun++;
      if ({usrdoneo, usrdonets} !== 2'b01) begin
        testsFailed++;
        $display("[TB] FAIL done_release_%0d got %b expected 01", i, {usrdoneo, usrdonets});
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_run_stop();
    logic obs [14];
    int   rises, falls;
    logic prev;
    rises = 0; falls = 0; prev = 1'b0;
    for (int k = 0; k < 14; k++) begin
      req = (k < 7);
      tick();
      obs[k] = usrcclko;
      if (cclkRise === 1'b1) rises++;
      if (prev === 1'b1 && usrcclko === 1'b0) falls++;
      prev = usrcclko;
    end
    testsRun++;
    if ({obs[6], obs[7], obs[8], obs[13]} !== 4'b1100) begin
      testsFailed++;
      $display("[TB] FAIL run_stop_wave got %b expected 1100", {obs[6], obs[7], obs[8], obs[13]});
    end
    testsRun++;
    if (rises != 2 || falls != 2) begin
      testsFailed++;
      $display("[TB] FAIL run_stop_edges got rises=%0d falls=%0d expected 2 and 2", rises, falls);
    end
  endtask

  task automatic test_random_run();
    req = 1'b0;
    for (int k = 0; k < NRAND; k++) begin
      if ($urandom_range(0, 9) == 0) req = ~req;
      histReq[k] = req;
      tick();
      obsHi[k]   = usrcclko;
      obsRise[k] = cclkRise;
    end
    req = 1'b0;
    repeat (10) tick();
    buildRunModel(NRAND);
    for (int k = 0; k < NRAND; k++) begin
      testsRun++;
      if ({obsHi[k], obsRise[k]} !== {expHi[k], expRise[k]}) begin
        testsFailed++;
        $display("[TB] FAIL random_run_cycle_%0d got %b expected %b", k,
                 {obsHi[k], obsRise[k]}, {expHi[k], expRise[k]});
      end
    end
  endtask

  task automatic test_conflict();
    bit   found;
    int   bad;
    logic prev;
    req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (usrcclko === 1'b1) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL conflict_run_start got timeout expected cclk high");
    end
    preq = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (progPending === 1'b1) found = 1'b1;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    testsRun++;
    if (pack !== 1'b1 || !found) begin
      testsFailed++;
      $display("[TB] FAIL conflict_pack got %b expected 1", pack);
    end
    prev = usrcclko;
    found = 1'b0;
    for (int i = 0; i < 4 * DIV + 2 && !found; i++) begin
      tick();
      if (prev === 1'b1 && usrcclko === 1'b0) found = 1'b1;
      prev = usrcclko;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL conflict_final_fall got timeout expected falling edge");
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (usrcclko !== 1'b0 || cclkRise !== 1'b0) bad++;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL conflict_parked got %0d active cycles expected 0", bad);
    end
    preq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (pack === 1'b0) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL conflict_pack_release got timeout expected pack 0");
    end
    found = 1'b0;
    for (int i = 0; i < 2 * DIV + 4 && !found; i++) begin
      tick();
      if (usrcclko === 1'b1) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL conflict_resume got timeout expected cclk high");
    end
    req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_async_reset();
    bit found;
    usrDone = 1'b1;
    req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (usrcclko === 1'b1 && usrdoneo === 1'b1) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL async_reset_setup got timeout expected cclk and done high");
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if ({usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending} !== 8'b01010000) begin
      testsFailed++;
      $display("[TB] FAIL async_reset got %b expected %b",
               {usrcclko, usrcclkts, usrdoneo, usrdonets, pack, ready, cclkRise, progPending}, 8'b01010000);
    end
    tick();
    rst = 1'b0;
    req = 1'b0;
    usrDone = 1'b0;
    repeat (2) tick();
    testsRun++;
    if ({ready, usrcclkts, usrcclko} !== 3'b010) begin
      testsFailed++;
      $display("[TB] FAIL after_async_reset got %b expected 010", {ready, usrcclkts, usrcclko});
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_startup();
    test_done();
    test_run_stop();
    test_random_run();
    test_conflict();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
